ysyx_25040105_inst_fetch: RTL and testbench

//  Instruction fetch stage feeding the IDU. Owns the PC register and issues one

---
 rtl/ysyx_25040105_inst_fetch.sv | 137 +++++++++++++
 tb/tb_ysyx_25040105_inst_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040105_inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to a
// variable-latency imem and holds the fetched word until decode accepts it.
module ysyx_25040105_inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_redirect_valid,
   input  logic [31:0]      i_redirect_pc,
   output logic             o_imem_req_valid,
   input  logic             i_imem_req_ready,
   output logic [31:0]      o_imem_req_addr,
   input  logic             i_imem_rsp_valid,
   input  logic [31:0]      i_imem_rsp_data,
   input  logic             i_imem_rsp_err,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [31:0]      o_out_pc,
   output logic [31:0]      o_out_inst,
   output logic             o_out_fault,
   output logic [CNT_W-1:0] o_fetch_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [31:0]       r_pc, w_pc_nxt;
   logic              r_kill, w_kill_nxt;
   logic [31:0]       r_out_pc, w_out_pc_nxt;
   logic [31:0]       r_out_inst, w_out_inst_nxt;
   logic              r_out_fault, w_out_fault_nxt;
   logic [CNT_W-1:0]  r_cnt;

   logic w_req_hs, w_out_hs, w_misalign, w_outstanding;

   assign w_req_hs   = (r_state == S_REQ) && i_imem_req_ready;
   assign w_out_hs   = (r_state == S_HOLD) && i_out_ready;
   assign w_misalign = (i_redirect_pc[1:0] != 2'b00);
   // A request is still in flight after this edge: just accepted, or waited on
   // with no response arriving now.
   assign w_outstanding = w_req_hs || ((r_state == S_WAIT) && !i_imem_rsp_valid);

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_kill_nxt      = r_kill;
      w_out_pc_nxt    = r_out_pc;
      w_out_inst_nxt  = r_out_inst;
      w_out_fault_nxt = r_out_fault;

      // A killed response is dropped wherever it turns up.
      if (i_imem_rsp_valid && r_kill)
         w_kill_nxt = 1'b0;

      unique case (r_state)
         S_IDLE: w_state_nxt = S_REQ;
         S_REQ: begin
            if (w_req_hs)
               w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (i_imem_rsp_valid) begin
               if (r_kill) begin
                  w_state_nxt = S_REQ;
               end else begin
                  w_state_nxt     = S_HOLD;
                  w_out_pc_nxt    = r_pc;
                  w_out_inst_nxt  = i_imem_rsp_data;
                  w_out_fault_nxt = i_imem_rsp_err;
               end
            end
         end
         S_HOLD: begin
            if (w_out_hs) begin
               if (r_out_fault) begin
                  w_state_nxt = S_HALT;
               end else begin
                  w_state_nxt = S_REQ;
                  w_pc_nxt    = r_pc + 32'd4;
               end
            end
         end
         S_HALT: w_state_nxt = S_HALT;
         default: w_state_nxt = S_IDLE;
      endcase

      // Redirect overrides whatever the state decided above.
      if (i_redirect_valid) begin
         w_pc_nxt = i_redirect_pc;
         if (w_outstanding)
            w_kill_nxt = 1'b1;
         if (w_misalign) begin
            w_state_nxt     = S_HOLD;
            w_out_pc_nxt    = i_redirect_pc;
            w_out_inst_nxt  = 32'd0;
            w_out_fault_nxt = 1'b1;
         end else begin
            w_state_nxt = w_outstanding ? S_WAIT : S_REQ;
            if (w_state_nxt == S_HOLD)
               w_state_nxt = S_REQ;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= S_IDLE;
         r_pc        <= RESET_PC;
         r_kill      <= 1'b0;
         r_out_pc    <= 32'd0;
         r_out_inst  <= 32'd0;
         r_out_fault <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_kill      <= w_kill_nxt;
         r_out_pc    <= w_out_pc_nxt;
         r_out_inst  <= w_out_inst_nxt;
         r_out_fault <= w_out_fault_nxt;
         if (w_out_hs)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_imem_req_valid = (r_state == S_REQ);
   assign o_imem_req_addr  = r_pc;
   assign o_out_valid      = (r_state == S_HOLD);
   assign o_out_pc         = r_out_pc;
   assign o_out_inst       = r_out_inst;
   assign o_out_fault      = r_out_fault;
   assign o_fetch_cnt      = r_cnt;

endmodule

// File: tb/tb_ysyx_25040105_inst_fetch.sv
// Bench for the fetch stage: directed scenarios plus a randomized run checked
// against a stream model (expected PC, memory contents, transfer count).
module tb_ysyx_25040105_inst_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst, redir_v, req_ready, rsp_valid, rsp_err, out_ready;
   logic [31:0] redir_pc, rsp_data;
   logic        req_valid, out_valid, out_fault;
   logic [31:0] req_addr, out_pc, out_inst, fetch_cnt;

   always #5 clk = ~clk;

   ysyx_25040105_inst_fetch #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_redirect_valid(redir_v), .i_redirect_pc(redir_pc),
      .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready),
      .o_imem_req_addr(req_addr),
      .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
      .i_imem_rsp_err(rsp_err),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_pc(out_pc), .o_out_inst(out_inst), .o_out_fault(out_fault),
      .o_fetch_cnt(fetch_cnt)
   );

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
   endfunction

   // memory responder and stream model state
   bit          pend = 0, rdy_rand = 0, ordy_rand = 0, redir_rand = 0, auto_chk = 0;
   int          pend_cnt = 0, lat_min = 0, lat_max = 0, cyc = 0;
   logic [31:0] pend_addr = 0, err_addr = 32'h7000_0000;
   logic [31:0] exp_pc = RST_PC;
   int          exp_cnt = 0, n_req = 0, n_xfer = 0;
   logic [31:0] req_q[$], xfer_pc_q[$], xfer_inst_q[$];
   int          xfer_cyc_q[$];
   logic [31:0] last_req_addr, last_xfer_pc, last_xfer_inst;
   logic        last_xfer_fault;

   task automatic tick();
      logic        p_rv, p_rr, p_sv, p_ov, p_or, p_redir, p_of, p_rst;
      logic [31:0] p_addr, p_opc, p_oinst, p_tgt;
      p_rv = req_valid; p_rr = req_ready; p_sv = rsp_valid; p_addr = req_addr;
      p_ov = out_valid; p_or = out_ready; p_opc = out_pc; p_oinst = out_inst;
      p_of = out_fault; p_redir = redir_v; p_tgt = redir_pc; p_rst = rst;
      @(posedge clk); #1;
      cyc++;
      if (p_sv) pend = 0;
      if (!p_rst) begin
         exp_pc  = RST_PC;
         exp_cnt = 0;
      end else begin
         if (p_rv && p_rr) begin
            if (auto_chk) begin
               chk("one_outstanding", {31'b0, pend}, 32'd0);
               chk("req_addr", p_addr, exp_pc);
            end
            pend = 1; pend_addr = p_addr;
            pend_cnt = int'($urandom_range(lat_max, lat_min));
            n_req++; last_req_addr = p_addr; req_q.push_back(p_addr);
         end
         if (p_ov && p_or) begin
            exp_cnt++; n_xfer++;
            last_xfer_pc = p_opc; last_xfer_inst = p_oinst; last_xfer_fault = p_of;
            xfer_pc_q.push_back(p_opc); xfer_inst_q.push_back(p_oinst);
            xfer_cyc_q.push_back(cyc);
            if (auto_chk) begin
               chk("xfer_pc", p_opc, exp_pc);
               chk("xfer_inst", p_oinst, mem_word(exp_pc));
               chk("xfer_fault", {31'b0, p_of}, 32'd0);
            end
            exp_pc += 32'd4;
         end
         if (p_redir) exp_pc = p_tgt;
         if (auto_chk) begin
            chk("fetch_cnt", fetch_cnt, 32'(exp_cnt));
            if (p_ov && !p_or && !p_redir) begin
               chk("stall_valid", {31'b0, out_valid}, 32'd1);
               chk("stall_pc", out_pc, p_opc);
            end
         end
      end
      if (pend && pend_cnt == 0) begin
         rsp_valid = 1'b1;
         rsp_err   = (pend_addr == err_addr);
         rsp_data  = rsp_err ? 32'd0 : mem_word(pend_addr);
      end else begin
         rsp_valid = 1'b0; rsp_err = 1'b0; rsp_data = 32'd0;
         if (pend) pend_cnt--;
      end
      if (rdy_rand)   req_ready = ($urandom_range(3, 0) != 0);
      if (ordy_rand)  out_ready = $urandom_range(1, 0) == 1;
      if (redir_rand) begin
         redir_v  = ($urandom_range(19, 0) == 0);
         redir_pc = RST_PC + (32'($urandom_range(255, 0)) << 2);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0; req_ready = 1'b0; out_ready = 1'b0; redir_v = 1'b0;
      tick(); tick();
      rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          nr, nx, nx0;
      logic [31:0] h_pc, h_inst, h_cnt, old_addr;
      rst = 1'b0; redir_v = 1'b0; redir_pc = 32'd0; req_ready = 1'b1;
      rsp_valid = 1'b0; rsp_data = 32'd0; rsp_err = 1'b0; out_ready = 1'b0;

      // reset state
      tick(); tick();
      chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_out_fault", {31'b0, out_fault}, 32'd0);
      chk("rst_cnt", fetch_cnt, 32'd0);
      chk("rst_addr", req_addr, RST_PC);

      // sequential fetch, zero-wait memory
      rst = 1'b1; out_ready = 1'b1; req_ready = 1'b1;
      tick();
      chk("first_req_valid", {31'b0, req_valid}, 32'd1);
      for (int i = 0; i < 40 && n_xfer < 3; i++) tick();
      chk("seq_xfers", 32'(n_xfer), 32'd3);
      chk("seq_req0", req_q[0], 32'h8000_0000);
      chk("seq_req1", req_q[1], 32'h8000_0004);
      chk("seq_req2", req_q[2], 32'h8000_0008);
      chk("seq_pc2", xfer_pc_q[2], 32'h8000_0008);
      chk("seq_inst0", xfer_inst_q[0], mem_word(32'h8000_0000));
      chk("seq_cnt", fetch_cnt, 32'd3);
      chk("seq_gap", 32'(xfer_cyc_q[2] - xfer_cyc_q[1]), 32'd3);

      // decode stall in HOLD
      out_ready = 1'b0;
      for (int i = 0; i < 20 && !out_valid; i++) tick();
      chk("stall_reach_hold", {31'b0, out_valid}, 32'd1);
      h_pc = out_pc; h_inst = out_inst; h_cnt = fetch_cnt;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_valid", {31'b0, out_valid}, 32'd1);
         chk("hold_pc", out_pc, h_pc);
         chk("hold_inst", out_inst, h_inst);
         chk("hold_no_req", {31'b0, req_valid}, 32'd0);
         chk("hold_cnt", fetch_cnt, h_cnt);
      end
      out_ready = 1'b1;
      tick();
      chk("hold_release_cnt", fetch_cnt, h_cnt + 32'd1);
      chk("hold_release_pc", last_xfer_pc, h_pc);

      // redirect coinciding with the request handshake
      req_ready = 1'b0;
      for (int i = 0; i < 20 && !req_valid; i++) tick();
      chk("t3_in_req", {31'b0, req_valid}, 32'd1);
      nr = n_req; nx = n_xfer; old_addr = req_addr;
      req_ready = 1'b1; redir_v = 1'b1; redir_pc = 32'h8000_0100;
      tick();
      redir_v = 1'b0;
      chk("t3_old_req_addr", last_req_addr, old_addr);
      chk("t3_wait", {31'b0, req_valid}, 32'd0);
      for (int i = 0; i < 20 && n_req < nr + 2; i++) tick();
      chk("t3_new_req", req_q[nr+1], 32'h8000_0100);
      for (int i = 0; i < 20 && n_xfer == nx; i++) tick();
      chk("t3_out_pc", xfer_pc_q[nx], 32'h8000_0100);
      chk("t3_out_inst", xfer_inst_q[nx], mem_word(32'h8000_0100));

      // access fault at 0x8000_0010, halt, resume on redirect
      do_reset();
      err_addr = 32'h8000_0010; out_ready = 1'b1; req_ready = 1'b1;
      nx = n_xfer;
      for (int i = 0; i < 80 && n_xfer < nx + 5; i++) tick();
      chk("err_pc", last_xfer_pc, 32'h8000_0010);
      chk("err_fault", {31'b0, last_xfer_fault}, 32'd1);
      chk("err_inst", last_xfer_inst, 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("halt_idle", {30'b0, req_valid, out_valid}, 32'd0);
      end
      err_addr = 32'h7000_0000;
      redir_v = 1'b1; redir_pc = 32'h8000_0000;
      tick();
      redir_v = 1'b0;
      chk("resume_req", {31'b0, req_valid}, 32'd1);
      chk("resume_addr", req_addr, 32'h8000_0000);

      // misaligned redirect while requesting
      req_ready = 1'b0; out_ready = 1'b0;
      redir_v = 1'b1; redir_pc = 32'h8000_0102;
      tick();
      redir_v = 1'b0;
      chk("mis_valid", {31'b0, out_valid}, 32'd1);
      chk("mis_fault", {31'b0, out_fault}, 32'd1);
      chk("mis_pc", out_pc, 32'h8000_0102);
      chk("mis_inst", out_inst, 32'd0);
      req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mis_no_req", {31'b0, req_valid}, 32'd0);
      end
      h_cnt = fetch_cnt;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("mis_accept_cnt", fetch_cnt, h_cnt + 32'd1);
      chk("mis_halt", {30'b0, req_valid, out_valid}, 32'd0);

      // misaligned redirect while a request is outstanding
      lat_min = 3; lat_max = 3;
      redir_v = 1'b1; redir_pc = 32'h8000_0200;
      tick();
      redir_v = 1'b0;
      chk("mw_req", {31'b0, req_valid}, 32'd1);
      tick();
      redir_v = 1'b1; redir_pc = 32'h8000_0206;
      tick();
      redir_v = 1'b0;
      for (int i = 0; i < 10 && pend; i++) tick();
      chk("mw_pc", out_pc, 32'h8000_0206);
      chk("mw_inst", out_inst, 32'd0);
      chk("mw_flags", {29'b0, out_valid, out_fault, req_valid}, 32'd6);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // reset while waiting; the late response must be ignored
      redir_v = 1'b1; redir_pc = 32'h8000_000c;
      tick();
      redir_v = 1'b0;
      tick();
      chk("rw_waiting", {31'b0, pend}, 32'd1);
      rst = 1'b0; req_ready = 1'b0;
      tick();
      chk("rw_rst_flags", {30'b0, req_valid, out_valid}, 32'd0);
      chk("rw_rst_cnt", fetch_cnt, 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 10 && pend; i++) tick();
      chk("rw_ignored", {30'b0, req_valid, out_valid}, 32'd2);
      chk("rw_addr", req_addr, RST_PC);
      lat_min = 0; lat_max = 0; req_ready = 1'b1; out_ready = 1'b1;
      nx = n_xfer;
      for (int i = 0; i < 20 && n_xfer == nx; i++) tick();
      chk("rw_pc", last_xfer_pc, RST_PC);
      chk("rw_inst", last_xfer_inst, mem_word(RST_PC));
      chk("rw_cnt", fetch_cnt, 32'd1);

      // randomized traffic with aligned redirects against the stream model
      do_reset();
      nx0 = n_xfer;
      lat_min = 0; lat_max = 3;
      rdy_rand = 1; ordy_rand = 1; redir_rand = 1; auto_chk = 1;
      repeat (800) tick();
      rdy_rand = 0; ordy_rand = 0; redir_rand = 0; auto_chk = 0;
      redir_v = 1'b0;
      chk("rand_progress", {31'b0, (n_xfer - nx0) > 20}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
